alu_time_redundancy_ctrl: RTL and testbench

Execute-stage ALU wrapper implementing time-redundant execution for the pipelined RISC-V core. Each ALU operation is computed on the same internal ALU in consecutive cycles. Results are compared, and a third pass with majority vote runs on mismatch. The block drives `ALU_Busy_Stall`, which the hazard unit uses to stall Fetch/Decode and suppress Execute flush while re-execution is in progress.

---
 rtl/alu_time_redundancy_ctrl.sv | 106 ++++++++++
 tb/tb_alu_time_redundancy_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_time_redundancy_ctrl.sv
// alu_time_redundancy_ctrl: ALU wrapper running each op twice on one ALU, with a
// third voting pass on mismatch; stalls the pipeline while re-executing.
module alu_time_redundancy_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tr_enable,
  input  logic             ValidE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [2:0]       ALUControlE,
  input  logic [1:0]       inj_pass,
  input  logic [WIDTH-1:0] inj_mask,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             ZeroE,
  output logic             ResultValidE,
  output logic             ALU_Busy_Stall,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);
  typedef enum logic [1:0] {IDLE, EXEC2, EXEC3} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_opa, r_opb, r_r1, r_r2, w_a, w_b, w_raw, w_res, w_result;
  logic [2:0] r_ctl, w_ctl;
  logic [1:0] w_pass;
  logic [CNT_W-1:0] r_corr, r_uncorr;
  logic w_start, w_busy, w_valid, w_corr, w_uncorr;
  // Passes 2 and 3 replay the operands captured during pass 1.
  assign w_a = (r_state == IDLE) ? SrcAE : r_opa;
  assign w_b = (r_state == IDLE) ? SrcBE : r_opb;
  assign w_ctl = (r_state == IDLE) ? ALUControlE : r_ctl;
  assign w_raw = (w_ctl == 3'd0) ? w_a + w_b :
                 (w_ctl == 3'd1) ? w_a - w_b :
                 (w_ctl == 3'd2) ? w_a & w_b :
                 (w_ctl == 3'd3) ? w_a | w_b :
                 (w_ctl == 3'd4) ? w_a ^ w_b :
                 (w_ctl == 3'd5) ? {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)} : '0;
  assign w_pass = (r_state == IDLE) ? 2'd1 : (r_state == EXEC2) ? 2'd2 : 2'd3;
  assign w_res = w_raw ^ ((inj_pass == w_pass) ? inj_mask : '0);
  assign w_start = (r_state == IDLE) && ValidE && tr_enable;
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_valid = 1'b0;
    w_result = w_res;
    w_corr = 1'b0;
    w_uncorr = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = w_start;
        w_valid = ValidE && !tr_enable;
        w_next = w_start ? EXEC2 : IDLE;
      end
      EXEC2: begin
        w_result = r_r1;
        w_valid = (w_res == r_r1);
        w_busy = !w_valid;
        w_next = w_valid ? IDLE : EXEC3;
      end
      EXEC3: begin
        w_valid = 1'b1;
        w_next = IDLE;
        w_corr = (w_res == r_r1) || (w_res == r_r2);
        w_uncorr = !w_corr;
        w_result = (w_res != r_r1 && w_res == r_r2) ? r_r2 : r_r1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_opa <= '0;
      r_opb <= '0;
      r_ctl <= '0;
      r_r1 <= '0;
      r_r2 <= '0;
      r_corr <= '0;
      r_uncorr <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_r1 <= w_res;
        r_opa <= SrcAE;
        r_opb <= SrcBE;
        r_ctl <= ALUControlE;
      end
      if (r_state == EXEC2) r_r2 <= w_res;
      if (w_corr && !(&r_corr)) r_corr <= r_corr + 1'b1;
      if (w_uncorr && !(&r_uncorr)) r_uncorr <= r_uncorr + 1'b1;
    end
  end
  // Control outputs are forced low for the whole time reset is held.
  assign ALUResultE = w_result;
  assign ZeroE = (w_result == '0);
  assign ResultValidE = w_valid && rst;
  assign ALU_Busy_Stall = w_busy && rst;
  assign err_corrected = w_corr && rst;
  assign err_uncorrectable = w_uncorr && rst;
  assign corr_count = r_corr;
  assign uncorr_count = r_uncorr;
endmodule

// File: tb/tb_alu_time_redundancy_ctrl.sv
// tb_alu_time_redundancy_ctrl: randomized scoreboard bench; the driver pushes
// expected results, a negedge monitor pops them whenever ResultValidE is high.
module tb_alu_time_redundancy_ctrl;
  localparam int W = 32;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b0, tr_enable = 1'b0, ValidE = 1'b0;
  logic [W-1:0] SrcAE = '0, SrcBE = '0, inj_mask = '0;
  logic [2:0] ALUControlE = '0;
  logic [1:0] inj_pass = '0;
  logic [W-1:0] ALUResultE;
  logic ZeroE, ResultValidE, ALU_Busy_Stall, err_corrected, err_uncorrectable;
  logic [CW-1:0] corr_count, uncorr_count;
  typedef struct {
    logic [W-1:0] res;
    logic corr;
    logic uncorr;
    logic [CW-1:0] cc;
    logic [CW-1:0] uc;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_err = 0;
  int m_cc = 0, m_uc = 0;
  localparam int SAT = (1 << CW) - 1;
  alu_time_redundancy_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .tr_enable(tr_enable), .ValidE(ValidE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .inj_pass(inj_pass), .inj_mask(inj_mask), .ALUResultE(ALUResultE),
    .ZeroE(ZeroE), .ResultValidE(ResultValidE), .ALU_Busy_Stall(ALU_Busy_Stall),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (signed'(a) < signed'(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic scramble;
    ValidE = 1'($urandom);
    tr_enable = 1'($urandom);
    SrcAE = $urandom;
    SrcBE = $urandom;
    ALUControlE = 3'($urandom);
  endtask
  // Called one time unit after a rising edge with the DUT idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                       input logic tr, input logic [W-1:0] m1, input logic [W-1:0] m2,
                       input logic [W-1:0] m3, input logic abort);
    logic [W-1:0] g, r1, r2, r3;
    exp_t e;
    int extra;
    g = ref_alu(a, b, c);
    r1 = g ^ m1;
    r2 = g ^ m2;
    r3 = g ^ m3;
    e.corr = 1'b0;
    e.uncorr = 1'b0;
    if (!tr) begin
      e.res = r1;
      extra = 0;
    end else if (r1 == r2) begin
      e.res = r1;
      extra = 1;
    end else begin
      extra = 2;
      e.corr = (r3 == r1) || (r3 == r2);
      e.uncorr = !e.corr;
      e.res = e.corr ? r3 : r1;
    end
    e.cc = CW'(m_cc);
    e.uc = CW'(m_uc);
    ValidE = 1'b1; tr_enable = tr; SrcAE = a; SrcBE = b; ALUControlE = c;
    inj_pass = 2'd1; inj_mask = m1;
    if (!abort) begin
      q.push_back(e);
      if (e.corr && m_cc < SAT) m_cc++;
      if (e.uncorr && m_uc < SAT) m_uc++;
    end
    #3;
    chk("corr_count_idle", W'(corr_count), W'(e.cc));
    chk("uncorr_count_idle", W'(uncorr_count), W'(e.uc));
    chk("busy_pass1", W'(ALU_Busy_Stall), W'(tr));
    chk("valid_pass1", W'(ResultValidE), W'(!tr));
    tick;
    if (tr) begin
      scramble;
      inj_pass = 2'd2; inj_mask = m2;
      #3;
      chk("busy_pass2", W'(ALU_Busy_Stall), W'(extra == 2));
      chk("valid_pass2", W'(ResultValidE), W'(extra == 1));
      tick;
      if (extra == 2) begin
        scramble;
        inj_pass = 2'd3; inj_mask = m3;
        if (abort) begin
          #1 rst = 1'b0;
          #1;
          chk("abort_busy", W'(ALU_Busy_Stall), 0);
          chk("abort_valid", W'(ResultValidE), 0);
          chk("abort_corr_count", W'(corr_count), 0);
          chk("abort_uncorr_count", W'(uncorr_count), 0);
          m_cc = 0;
          m_uc = 0;
          ValidE = 1'b0;
          #5 rst = 1'b1;
        end else begin
          #3;
          chk("busy_pass3", W'(ALU_Busy_Stall), 0);
          chk("valid_pass3", W'(ResultValidE), 1);
        end
        tick;
      end
    end
    ValidE = 1'b0; inj_pass = 2'd0; inj_mask = '0;
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      ValidE = 1'b0;
      SrcAE = $urandom;
      tr_enable = 1'($urandom);
      tick;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ResultValidE) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", W'(ResultValidE), 0);
      end else begin
        e = q.pop_front();
        chk("result", ALUResultE, e.res);
        chk("zero", W'(ZeroE), W'(e.res == 0));
        chk("err_corrected", W'(err_corrected), W'(e.corr));
        chk("err_uncorrectable", W'(err_uncorrectable), W'(e.uncorr));
        chk("busy_at_valid", W'(ALU_Busy_Stall), 0);
        chk("corr_count_at_valid", W'(corr_count), W'(e.cc));
        chk("uncorr_count_at_valid", W'(uncorr_count), W'(e.uc));
      end
    end else if (err_corrected || err_uncorrectable) begin
      chk("pulse_without_valid", W'({err_corrected, err_uncorrectable}), 0);
    end
  end
  initial begin
    logic [W-1:0] m1, m2, m3;
    int sc;
    SrcAE = 5; SrcBE = 7; ALUControlE = 3'd0; ValidE = 1'b1; tr_enable = 1'b1;
    #2;
    chk("reset_result", ALUResultE, 12);
    chk("reset_zero", W'(ZeroE), 0);
    chk("reset_valid", W'(ResultValidE), 0);
    chk("reset_busy", W'(ALU_Busy_Stall), 0);
    chk("reset_counts", W'({corr_count, uncorr_count}), 0);
    ValidE = 1'b0;
    #5 rst = 1'b1;
    tick;
    do_op(5, 7, 3'd0, 1'b1, 0, 0, 0, 1'b0);
    do_op(10, 3, 3'd1, 1'b1, 0, 1, 0, 1'b0);
    do_op(32'hF0F0, 32'hFF00, 3'd2, 1'b1, 32'h8000_0000, 0, 0, 1'b0);
    do_op(32'h1234, 32'h4321, 3'd0, 1'b1, 1, 2, 4, 1'b0);
    do_op(32'hFFFF_FFFF, 1, 3'd5, 1'b0, 0, 0, 0, 1'b0);
    do_op(1, 32'hFFFF_FFFF, 3'd5, 1'b1, 0, 0, 0, 1'b0);
    do_op(32'h55, 32'h55, 3'd4, 1'b1, 0, 0, 0, 1'b0);
    gap(2);
    do_op(3, 4, 3'd3, 1'b1, 8, 16, 32, 1'b1);
    gap(1);
    for (int i = 0; i < SAT + 5; i++) do_op($urandom, $urandom, 3'($urandom), 1'b1, 0, $urandom | 1, 0, 1'b0);
    gap(1);
    chk("corr_saturated", W'(corr_count), W'(SAT));
    for (int i = 0; i < 400; i++) begin
      sc = $urandom_range(0, 5);
      m1 = (sc == 2 || sc == 4) ? $urandom : 0;
      m2 = (sc == 3) ? $urandom : 0;
      m3 = (sc == 4) ? $urandom : 0;
      if (sc == 5) begin
        m1 = 1 << $urandom_range(0, 2);
        m2 = 1 << $urandom_range(0, 2);
        m3 = 1 << $urandom_range(0, 2);
      end
      do_op($urandom, $urandom, 3'($urandom), $urandom_range(0, 3) != 0, m1, m2, m3, 1'b0);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    gap(3);
    chk("queue_drained", W'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
